ga_cas_ready_gen: RTL and testbench



---
 rtl/ga_cas_ready_gen.sv | 57 +++++
 tb/tb_ga_cas_ready_gen.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ga_cas_ready_gen.sv
// CAS_N and CPU READY generation for the CPC gate array, decoded from the
// 16 MHz Johnson sequencer state.
module ga_cas_ready_gen (
  input  logic       clk,
  input  logic       reset,
  input  logic       cen_16,
  input  logic [7:0] S,
  input  logic       MREQ_N,
  input  logic       ROMEN_N,
  input  logic       CASAD_N,
  output logic       CAS_N,
  output logic       READY
);

  logic vid_cas;
  logic cpu_slot;
  logic cpu;
  logic ready_set;
  logic ready_q;

  // Video strobes use only the first three ticks of each byte window, so
  // E0 and 01 become the CAS-high gaps that split the two pulses.
  always_comb begin
    vid_cas  = 1'b0;
    cpu_slot = 1'b0;
    case (S)
      8'hFC, 8'hF8, 8'hF0: vid_cas  = 1'b1;
      8'hC0, 8'h80, 8'h00: vid_cas  = 1'b1;
      8'h0F, 8'h1F, 8'h3F: cpu_slot = 1'b1;
      default: ;
    endcase
  end

  assign cpu = cpu_slot & ~MREQ_N & ROMEN_N;

  always_ff @(posedge clk) begin
    if (reset) begin
      CAS_N <= 1'b1;
    end else if (cen_16) begin
      CAS_N <= ~(vid_cas | cpu);
    end
  end

  assign ready_set = S[3] & ~S[6];

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= ready_set | (ready_q & ~CASAD_N);
    end
  end

  // Held state is masked during reset so only the set term reaches READY.
  assign READY = ready_set | (~reset & ready_q & ~CASAD_N);

endmodule

// File: tb/tb_ga_cas_ready_gen.sv
// Directed self-checking bench for ga_cas_ready_gen.
module tb_ga_cas_ready_gen;

  logic       clk;
  logic       reset;
  logic       cen_16;
  logic [7:0] S;
  logic       MREQ_N;
  logic       ROMEN_N;
  logic       CASAD_N;
  logic       CAS_N;
  logic       READY;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [7:0]  johnson [16];
  // Bit i set = CAS_N expected low on the tick after johnson[i].
  logic [15:0] vid_mask = 16'hDC01;
  logic [15:0] cpu_mask = 16'h0070;

  ga_cas_ready_gen dut (
    .clk     (clk),
    .reset   (reset),
    .cen_16  (cen_16),
    .S       (S),
    .MREQ_N  (MREQ_N),
    .ROMEN_N (ROMEN_N),
    .CASAD_N (CASAD_N),
    .CAS_N   (CAS_N),
    .READY   (READY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input logic [7:0] s, input logic en);
    S      = s;
    cen_16 = en;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cas(input string name, input logic exp);
    n_checks++;
    if (CAS_N !== exp) begin
      n_fail++;
      $display("FAIL %s: CAS_N=%b expected %b (S=%h)", name, CAS_N, exp, S);
    end
  endtask

  task automatic chk_ready(input string name, input logic exp);
    n_checks++;
    if (READY !== exp) begin
      n_fail++;
      $display("FAIL %s: READY=%b expected %b (S=%h CASAD_N=%b)", name, READY, exp, S, CASAD_N);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; MREQ_N = 1'b0; ROMEN_N = 1'b1; CASAD_N = 1'b1;
    tick(8'h55, 1'b0);
    tick(8'h0F, 1'b1);
    chk_cas("reset_cas", 1'b1);
    chk_ready("reset_ready_set", 1'b1);
    S = 8'h00; #1;
    chk_ready("reset_ready_noset", 1'b0);
    reset = 1'b0; MREQ_N = 1'b1;
    tick(8'h00, 1'b0);
    chk_ready("post_reset_ready", 1'b0);
    chk_cas("post_reset_cas_held", 1'b1);
  endtask

  task automatic test_video;
    MREQ_N = 1'b1; ROMEN_N = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 16; i++) begin
        tick(johnson[i], 1'b1);
        chk_cas("video", ~vid_mask[i]);
      end
  endtask

  task automatic test_cpu_access;
    MREQ_N = 1'b0; ROMEN_N = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick(johnson[i], 1'b1);
      chk_cas("cpu_ram", ~(vid_mask[i] | cpu_mask[i]));
    end
    ROMEN_N = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick(johnson[i], 1'b1);
      chk_cas("cpu_rom", ~vid_mask[i]);
    end
    ROMEN_N = 1'b1;
    tick(8'h0F, 1'b1);
    chk_cas("mreq_win_start", 1'b0);
    MREQ_N = 1'b1;
    tick(8'h1F, 1'b1);
    chk_cas("mreq_rise_mid", 1'b1);
  endtask

  task automatic test_cen_gating;
    logic exp;
    MREQ_N = 1'b0; ROMEN_N = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp = ~(vid_mask[i] | cpu_mask[i]);
      tick(johnson[i], 1'b1);
      chk_cas("cen_enabled", exp);
      for (int k = 0; k < 3; k++) begin
        tick(exp ? 8'hFC : 8'h55, 1'b0);
        chk_cas("cen_disabled_hold", exp);
      end
    end
    MREQ_N = 1'b1;
  endtask

  task automatic test_ready;
    S = 8'h0F; CASAD_N = 1'b1; cen_16 = 1'b0; #1;
    chk_ready("ready_set_now", 1'b1);
    @(posedge clk); #1;
    S = 8'h7F; CASAD_N = 1'b0; #1;
    chk_ready("ready_hold_now", 1'b1);
    @(posedge clk); #1;
    chk_ready("ready_hold_next", 1'b1);
    CASAD_N = 1'b1; #1;
    chk_ready("ready_clr_now", 1'b0);
    @(posedge clk); #1;
    chk_ready("ready_clr_next", 1'b0);
    CASAD_N = 1'b0;
    @(posedge clk); #1;
    chk_ready("ready_stays_clr", 1'b0);
    S = 8'h3F; CASAD_N = 1'b1; #1;
    chk_ready("ready_set_dominates", 1'b1);
    S = 8'hF8; #1;
    chk_ready("ready_f8_noset", 1'b0);
  endtask

  task automatic test_illegal;
    MREQ_N = 1'b1; ROMEN_N = 1'b1;
    tick(8'hFC, 1'b1);
    chk_cas("illegal_pre_low", 1'b0);
    tick(8'h55, 1'b1);
    chk_cas("illegal_s55", 1'b1);
  endtask

  initial begin
    johnson = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};
    reset = 1'b1; cen_16 = 1'b0; S = 8'h00;
    MREQ_N = 1'b1; ROMEN_N = 1'b1; CASAD_N = 1'b1;
    test_reset;
    test_video;
    test_cpu_access;
    test_cen_gating;
    test_ready;
    test_illegal;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
